// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with one holding register per channel.
// Routes by in_sel (mode 0) or by a round-robin pointer (mode 1).
module demux_stream_1ton #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               mode,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [SELW-1:0]    cur_ch,
    output logic               drop_err
);

    logic [SELW-1:0]           tgt;
    logic                      range_ok;
    logic                      accept;
    logic                      load;
    logic [N-1:0]              valid_q;
    logic [N-1:0][WIDTH-1:0]   data_q;

    assign tgt      = mode ? cur_ch : in_sel;
    assign range_ok = (32'(tgt) < 32'(N));

    // Out-of-range targets are always consumed so the producer never hangs.
    always_comb begin
        in_ready = 1'b1;
        if (range_ok) begin
            in_ready = !valid_q[tgt] || out_ready[tgt];
        end
    end

    assign accept    = in_valid && in_ready;
    assign load      = accept && range_ok;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            data_q   <= '0;
            cur_ch   <= '0;
            drop_err <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load && (tgt == SELW'(k))) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= in_data;
                end else if (out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            drop_err <= accept && !range_ok;
            if (accept && mode) begin
                cur_ch <= (cur_ch == SELW'(N - 1)) ? '0 : cur_ch + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: reference model with per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_demux_stream_1ton;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int SW = 3;
    localparam int N6 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           in_valid, in_ready, mode, drop_err;
    logic [W-1:0]   in_data;
    logic [SW-1:0]  in_sel, cur_ch;
    logic [N-1:0]   out_valid, out_ready;
    logic [N*W-1:0] out_data;

    logic            rst6;
    logic            in_valid6, in_ready6, mode6, drop_err6;
    logic [W-1:0]    in_data6;
    logic [2:0]      in_sel6, cur_ch6;
    logic [N6-1:0]   out_valid6, out_ready6;
    logic [N6*W-1:0] out_data6;

    demux_stream_1ton #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cur_ch(cur_ch), .drop_err(drop_err)
    );

    demux_stream_1ton #(.WIDTH(W), .N(N6)) dut6 (
        .clk(clk), .rst(rst6), .in_valid(in_valid6), .in_ready(in_ready6),
        .in_data(in_data6), .in_sel(in_sel6), .mode(mode6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
        .cur_ch(cur_ch6), .drop_err(drop_err6)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    // Reference model: one slot per channel plus the round-robin pointer.
    logic         m_valid [N];
    logic [W-1:0] m_data  [N];
    int           m_ptr;
    logic         m_drop;
    bit           m_init = 1'b0;

    function automatic int tgt();
        return mode ? m_ptr : int'(in_sel);
    endfunction

    function automatic logic exp_ready();
        int t;
        t = tgt();
        if (t >= N) return 1'b1;
        return !m_valid[t] || out_ready[t];
    endfunction

    always @(posedge clk) begin
        m_init <= 1'b1;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] <= 1'b0;
                m_data[i]  <= '0;
            end
            m_ptr  <= 0;
            m_drop <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (in_valid && exp_ready() && tgt() == i) begin
                    m_valid[i] <= 1'b1;
                    m_data[i]  <= in_data;
                end else if (out_ready[i]) begin
                    m_valid[i] <= 1'b0;
                end
            end
            m_drop <= in_valid && (tgt() >= N);
            if (in_valid && exp_ready() && mode) m_ptr <= (m_ptr + 1) % N;
        end
    end

    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    always_comb begin
        ev = '0;
        ed = '0;
        for (int i = 0; i < N; i++) begin
            ev[i]       = m_valid[i];
            ed[i*W +: W] = m_data[i];
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("m_out_valid", 64'(out_valid), 64'(ev));
            chk("m_out_data", 64'(out_data), 64'(ed));
            chk("m_cur_ch", 64'(cur_ch), 64'(m_ptr));
            chk("m_drop_err", 64'(drop_err), 64'(m_drop));
            chk("m_in_ready", 64'(in_ready), 64'(exp_ready()));
        end
    end

    // Driver stability rule: a stalled beat must not change.
    logic         p_hold = 1'b0;
    logic [W-1:0] p_data;
    logic [SW-1:0] p_sel;
    always @(posedge clk) begin
        p_hold <= in_valid && !in_ready && !rst;
        p_data <= in_data;
        p_sel  <= in_sel;
    end
    always @(negedge clk) begin
        if (p_hold) begin
            assert (in_data == p_data && in_sel == p_sel)
                else $error("driver changed a stalled beat");
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic hold;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_sel = '0;
        mode = 1'b0; out_ready = '0;
        rst6 = 1'b1; in_valid6 = 1'b0; in_data6 = '0; in_sel6 = '0;
        mode6 = 1'b0; out_ready6 = '0;
        cyc(2);
        chk("rst_out_valid", 64'(out_valid), 64'h00);
        chk("rst_cur_ch", 64'(cur_ch), 64'h0);
        chk("rst_drop_err", 64'(drop_err), 64'h0);
        rst = 1'b0; rst6 = 1'b0; in_valid = 1'b0;
        cyc();
        chk("idle_out_valid", 64'(out_valid), 64'h00);

        // Addressed sweep
        out_ready = 8'hFF;
        for (int k = 0; k < N; k++) begin
            in_sel = SW'(k); in_data = W'(8'hA0 + k); in_valid = 1'b1;
            #1;
            chk("sweep_in_ready", 64'(in_ready), 64'h1);
            cyc();
            chk("sweep_out_valid", 64'(out_valid), 64'(1 << k));
            chk("sweep_out_data", 64'(out_data[k*W +: W]), 64'(8'hA0 + k));
        end
        in_valid = 1'b0;
        cyc();

        // Backpressure on channel 3
        out_ready = '0; in_sel = 3'd3; in_data = 8'h11; in_valid = 1'b1;
        #1;
        chk("bp_first_ready", 64'(in_ready), 64'h1);
        cyc();
        in_data = 8'h22;
        #1;
        chk("bp_second_ready", 64'(in_ready), 64'h0);
        chk("bp_hold_data", 64'(out_data[3*W +: W]), 64'h11);
        cyc();
        chk("bp_still_blocked", 64'(in_ready), 64'h0);
        out_ready = 8'h08;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'h1);
        cyc();
        in_valid = 1'b0; out_ready = '0;
        chk("bp_valid3", 64'(out_valid[3]), 64'h1);
        chk("bp_data3", 64'(out_data[3*W +: W]), 64'h22);
        out_ready = 8'hFF;
        cyc();

        // Auto wrap
        mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = W'(i); in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        chk("wrap_cur_ch", 64'(cur_ch), 64'h2);
        chk("wrap_data1", 64'(out_data[1*W +: W]), 64'h09);
        chk("wrap_data7", 64'(out_data[7*W +: W]), 64'h07);

        // Auto stall on channel 2
        out_ready = 8'hFB;
        for (int i = 0; i < N; i++) begin
            in_data = W'(8'h30 + i); in_valid = 1'b1;
            cyc();
        end
        in_data = 8'h99;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", 64'(in_ready), 64'h0);
            chk("stall_cur_ch", 64'(cur_ch), 64'h2);
            cyc();
        end
        out_ready = 8'hFF;
        #1;
        chk("unstall_ready", 64'(in_ready), 64'h1);
        cyc();
        in_valid = 1'b0;
        chk("unstall_cur_ch", 64'(cur_ch), 64'h3);
        chk("unstall_data2", 64'(out_data[2*W +: W]), 64'h99);
        chk("unstall_valid2", 64'(out_valid[2]), 64'h1);

        // Out-of-range drop on the N=6 instance
        in_sel6 = 3'd2; in_data6 = 8'h5A; in_valid6 = 1'b1;
        cyc();
        in_sel6 = 3'd7; in_data6 = 8'hEE;
        #1;
        chk("oor_in_ready", 64'(in_ready6), 64'h1);
        cyc();
        in_valid6 = 1'b0;
        chk("oor_drop_err", 64'(drop_err6), 64'h1);
        chk("oor_out_valid", 64'(out_valid6), 64'h04);
        chk("oor_data2", 64'(out_data6[2*W +: W]), 64'h5A);
        cyc();
        chk("oor_drop_pulse", 64'(drop_err6), 64'h0);
        chk("oor_valid_kept", 64'(out_valid6), 64'h04);
        rst6 = 1'b1; in_valid6 = 1'b1; in_sel6 = 3'd0;
        cyc();
        rst6 = 1'b0; in_valid6 = 1'b0;
        chk("midrst_valid6", 64'(out_valid6), 64'h00);
        chk("midrst_data6", 64'(out_data6), 64'h0);

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            #1;
            hold = in_valid && !in_ready && !rst;
            cyc();
            rst = ($urandom_range(0, 99) == 0);
            if (!hold) begin
                in_valid = $urandom_range(0, 2) != 0;
                in_data  = W'($urandom);
                in_sel   = SW'($urandom);
                mode     = $urandom_range(0, 1) == 1;
            end
            out_ready = N'($urandom) | N'($urandom);
        end
        rst = 1'b0; in_valid = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
